// File: rtl/mult_pkg.sv
// Shared types and sizing constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT     = 32;
  localparam int CNT_W_DEFAULT = 5;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int PROD_W_DEFAULT = prod_width(W_DEFAULT);

endpackage

// File: rtl/add_32b.sv
// W-bit ripple-carry adder with carry-in and carry-out.
module add_32b import mult_pkg::*; #(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[W];

endmodule

// File: rtl/mult32_seq_ctrl.sv
// Sequential WxW shift-add multiplier, one product bit per cycle, start/busy/done handshake.
// Define SIGNED_MULT_EN to honour signed_op (sign-magnitude load, negate on completion).
module mult32_seq_ctrl import mult_pkg::*; #(
  parameter int W     = W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo
);

  localparam int               PW       = prod_width(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PROD_ONE = {{(PW-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     mcand_r;
  // The adder carry is folded straight into the shift, so the stored
  // accumulator never needs a separate carry bit between iterations.
  logic [PW-1:0]    acc_r;
  logic             neg_r;
  logic             busy_r;
  logic             done_r;
  logic [W-1:0]     prod_hi_r;
  logic [W-1:0]     prod_lo_r;

  logic [W-1:0]     addend_s;
  logic [W-1:0]     sum_s;
  logic             cout_s;
  logic [PW-1:0]    step_s;
  logic [PW-1:0]    final_s;
  logic [W-1:0]     a_load_s;
  logic [W-1:0]     b_load_s;
  logic             neg_load_s;

`ifdef SIGNED_MULT_EN
  // Operand conditioning: signed requests load magnitudes and remember the result sign.
  always_comb begin
    a_load_s   = a;
    b_load_s   = b;
    neg_load_s = 1'b0;
    if (signed_op) begin
      a_load_s   = a[W-1] ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
      b_load_s   = b[W-1] ? (~b + {{(W-1){1'b0}}, 1'b1}) : b;
      neg_load_s = a[W-1] ^ b[W-1];
    end else begin
      a_load_s   = a;
      b_load_s   = b;
      neg_load_s = 1'b0;
    end
  end
`else
  assign a_load_s   = a;
  assign b_load_s   = b;
  // Unsigned-only build: signed_op is accepted on the port but forced off.
  assign neg_load_s = signed_op & 1'b0;
`endif

  assign addend_s = acc_r[0] ? mcand_r : {W{1'b0}};

  add_32b #(.W(W)) u_add (
    .a    (acc_r[PW-1:W]),
    .b    (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign step_s  = {cout_s, sum_s, acc_r[W-1:1]};
  assign final_s = neg_r ? (~step_s + PROD_ONE) : step_s;

  // Control FSM, iteration counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      mcand_r   <= {W{1'b0}};
      acc_r     <= {PW{1'b0}};
      neg_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      prod_hi_r <= {W{1'b0}};
      prod_lo_r <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            mcand_r <= a_load_s;
            acc_r   <= {{W{1'b0}}, b_load_s};
            neg_r   <= neg_load_s;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            prod_hi_r <= final_s[PW-1:W];
            prod_lo_r <= final_s[W-1:0];
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= CALC;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign prod_hi = prod_hi_r;
  assign prod_lo = prod_lo_r;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed self-checking bench for mult32_seq_ctrl (latency, products, start masking, reset).
module tb_mult32_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int checks;
  int errors;

  mult32_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Issue one operation from the current cycle (cycle 0) and follow it to done.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic sgn, input logic [63:0] exp_p, input logic glitch);
    int          busy_n;
    int          done_at;
    int          done_n;
    logic        held_ok;
    logic        busy_at_done;
    logic [63:0] prev;
    busy_n       = 0;
    done_at      = 0;
    done_n       = 0;
    held_ok      = 1'b1;
    busy_at_done = 1'b0;
    prev         = {prod_hi, prod_lo};
    a            = op_a;
    b            = op_b;
    signed_op    = sgn;
    start        = 1'b1;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      step();
      start     = 1'b0;
      a         = 32'hA5A5_A5A5;
      b         = 32'h5A5A_5A5A;
      signed_op = ~sgn;
      if (glitch && (k == 5 || k == 20)) start = 1'b1;
      if (busy) begin
        busy_n++;
        if ({prod_hi, prod_lo} !== prev) held_ok = 1'b0;
      end
      if (done) begin
        done_at      = k;
        done_n++;
        busy_at_done = busy;
      end
    end
    check_eq({tag, "_done_cycle"}, 64'(done_at), 64'd33);
    check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    check_eq({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    check_eq({tag, "_prod_held"}, 64'(held_ok), 64'd1);
    check_eq({tag, "_product"}, {prod_hi, prod_lo}, exp_p);
    step();
    check_eq({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int saw;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    a         = 32'd0;
    b         = 32'd0;
    step();
    step();
    check_eq("reset_state", {62'd0, busy, done}, 64'd0);
    check_eq("reset_prod", {prod_hi, prod_lo}, 64'd0);

    // Reset and start together: reset wins, nothing starts.
    a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check_eq("reset_start_busy0", 64'(busy), 64'd0);
    step();
    check_eq("reset_start_busy1", 64'(busy), 64'd0);

    run_op("mul_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0);
    run_op("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mul_zero", 32'h1234_5678, 32'd0, 1'b0, 64'd0, 1'b0);
    run_op("mul_deadbeef", 32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 64'h0000_000D_EADB_EEF0, 1'b1);
    // Issued in the cycle right after the previous done cycle.
    run_op("mul_b2b", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000, 1'b0);

`ifdef SIGNED_MULT_EN
    run_op("mul_sgn_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op("mul_sgn_m3xm5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_000F, 1'b0);
`else
    run_op("mul_sgn_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, 1'b0);
    run_op("mul_sgn_m3xm5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFF8_0000_000F, 1'b0);
`endif
    run_op("mul_uns_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b0);

    // Reset in cycle 10 of an operation clears everything, no done follows.
    a = 32'd7; b = 32'd9; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check_eq("midop_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("midop_reset_state", {62'd0, busy, done}, 64'd0);
    check_eq("midop_reset_prod", {prod_hi, prod_lo}, 64'd0);
    saw = 0;
    repeat (40) begin
      step();
      if (busy || done) saw++;
    end
    check_eq("midop_no_done", 64'(saw), 64'd0);

    run_op("mul_after_reset", 32'd7, 32'd9, 1'b0, 64'd63, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
